// File: rtl/spi_arb.sv
// spi_arb: round-robin arbiter/sequencer for two requesters sharing one SPI master.
// Optional watchdog release is built only when SPI_ARB_TIMEOUT_EN is defined.
module spi_arb #(
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic [15:0] data0,
   input  logic [15:0] data1,
   input  logic [2:0]  ss0,
   input  logic [2:0]  ss1,
   input  logic        SPI_done,
   input  logic [7:0]  EEP_data,
   output logic        wrt_SPI,
   output logic [15:0] SPI_data,
   output logic [2:0]  ss,
   output logic        done0,
   output logic        done1,
   output logic [7:0]  rdata,
   output logic        busy,
   output logic        timeout
);
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RELEASE} state_t;
   state_t state, nxt;
   logic last, gnt, pick, grant, fin, tmo;
`ifdef SPI_ARB_TIMEOUT_EN
   logic [15:0] cnt;
   always_ff @(posedge clk)
      if (rst) cnt <= '0;
      else cnt <= (state == WAIT) ? cnt + 16'd1 : '0;
`endif
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= nxt;
   always_comb
      nxt = (state == IDLE)   ? ((req0 | req1) ? LAUNCH : IDLE) :
            (state == LAUNCH) ? WAIT :
            (state == WAIT)   ? (fin ? RELEASE : WAIT) : IDLE;
   // a tie goes to the requester not served last; SPI_done beats a same-cycle watchdog expiry
   always_comb begin
      pick  = (req0 & req1) ? ~last : req1;
      grant = (state == IDLE) && (req0 | req1);
`ifdef SPI_ARB_TIMEOUT_EN
      tmo   = (state == WAIT) && !SPI_done && (cnt == 16'(TIMEOUT_CYC - 1));
`else
      tmo   = 1'b0;
`endif
      fin   = (state == WAIT) && (SPI_done || tmo);
   end
   always_ff @(posedge clk)
      if (rst) begin
         last     <= 1'b1;
         gnt      <= 1'b0;
         SPI_data <= '0;
         ss       <= '0;
         wrt_SPI  <= 1'b0;
         done0    <= 1'b0;
         done1    <= 1'b0;
         rdata    <= '0;
         busy     <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         if (grant) begin
            SPI_data <= pick ? data1 : data0;
            ss       <= pick ? ss1 : ss0;
            gnt      <= pick;
            last     <= pick;
         end
         if (fin) rdata <= tmo ? 8'hFF : EEP_data;
         wrt_SPI <= state == LAUNCH;
         done0   <= fin & ~gnt;
         done1   <= fin & gnt;
         timeout <= tmo;
         busy    <= nxt != IDLE;
      end
endmodule

// File: tb/tb_spi_arb.sv
// tb_spi_arb: vector table plus hand sequences for spi_arb; completions checked against a queue.
// Build with SPI_ARB_TIMEOUT_EN to exercise the watchdog (TIMEOUT_CYC=8).
module tb_spi_arb;
`ifdef SPI_ARB_TIMEOUT_EN
   localparam int TCYC = 8;
`else
   localparam int TCYC = 4096;
`endif
   logic clk = 1'b0, rst, req0, req1, SPI_done;
   logic [15:0] data0, data1, SPI_data;
   logic [2:0] ss0, ss1, ss;
   logic [7:0] EEP_data, rdata;
   logic wrt_SPI, done0, done1, busy, timeout;
   int errors = 0, checks = 0;

   typedef struct {logic g; logic [7:0] rd; logic to;} exp_t;
   typedef struct {logic r0, r1; logic [15:0] d0, d1; logic [2:0] s0, s1; logic [7:0] eep; int dly; logic g;} vec_t;
   exp_t q[$];
   vec_t v[7];

   spi_arb #(.TIMEOUT_CYC(TCYC)) dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
      .ss0(ss0), .ss1(ss1), .SPI_done(SPI_done), .EEP_data(EEP_data), .wrt_SPI(wrt_SPI),
      .SPI_data(SPI_data), .ss(ss), .done0(done0), .done1(done1), .rdata(rdata),
      .busy(busy), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // completions are popped in order and compared as they appear
   always @(negedge clk)
      if (!rst && (done0 || done1)) begin
         if (q.size() == 0) chk("unexpected_done", 32'({done1, done0}), 32'd0);
         else begin
            exp_t e;
            e = q.pop_front();
            chk("done_sel", 32'({done1, done0}), e.g ? 32'd2 : 32'd1);
            chk("rdata", 32'(rdata), 32'(e.rd));
            chk("timeout_flag", 32'(timeout), 32'(e.to));
         end
      end

   task automatic chk_reset();
      chk("rst_wrt", 32'(wrt_SPI), 0);
      chk("rst_data", 32'(SPI_data), 0);
      chk("rst_ss", 32'(ss), 0);
      chk("rst_done", 32'({done1, done0}), 0);
      chk("rst_rdata", 32'(rdata), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_timeout", 32'(timeout), 0);
   endtask

   task automatic launch(input logic g, input logic [15:0] d, input logic [2:0] s, input int exp_t_lat);
      int t = 0;
      while (!wrt_SPI && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("launch_seen", 32'(wrt_SPI), 1);
      if (exp_t_lat >= 0) chk("launch_latency", 32'(t), 32'(exp_t_lat));
      chk("launch_data", 32'(SPI_data), 32'(d));
      chk("launch_ss", 32'(ss), 32'(s));
      chk("launch_busy", 32'(busy), 1);
      @(negedge clk);
      chk("wrt_one_cycle", 32'(wrt_SPI), 0);
      chk("data_stable", 32'(SPI_data), 32'(d));
   endtask

   task automatic finish(input logic g, input logic [7:0] eep, input int d);
      int n = 0;
      exp_t e;
      e = '{g, eep, 1'b0};
      q.push_back(e);
      repeat ((d > TCYC - 2) ? TCYC - 2 : d) @(negedge clk);
      SPI_done = 1'b1;
      EEP_data = eep;
      do begin
         @(negedge clk);
         SPI_done = 1'b0;
         EEP_data = 8'h00;
         n++;
      end while (!(done0 || done1) && n < 50);
      chk("done_latency", 32'(n), 1);
      @(negedge clk);
      chk("busy_after_done", 32'(busy), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_time_limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; SPI_done = 1'b0;
      data0 = '0; data1 = '0; ss0 = '0; ss1 = '0; EEP_data = '0;
      v[0] = '{1'b1, 1'b0, 16'h13A5, 16'h0000, 3'b001, 3'b000, 8'h5C, 20, 1'b0};
      v[1] = '{1'b0, 1'b1, 16'h0000, 16'hBEEF, 3'b000, 3'b100, 8'hA7, 0, 1'b1};
      v[2] = '{1'b1, 1'b1, 16'h1111, 16'h2222, 3'b010, 3'b011, 8'h01, 3, 1'b0};
      v[3] = '{1'b0, 1'b1, 16'h1111, 16'h2222, 3'b010, 3'b011, 8'h02, 1, 1'b1};
      v[4] = '{1'b1, 1'b0, 16'h0000, 16'h2222, 3'b000, 3'b011, 8'hFF, 6, 1'b0};
      v[5] = '{1'b1, 1'b1, 16'hFFFF, 16'h8001, 3'b111, 3'b100, 8'h80, 2, 1'b1};
      v[6] = '{1'b1, 1'b0, 16'hFFFF, 16'h8001, 3'b111, 3'b100, 8'h3C, 4, 1'b0};
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk_reset();
      for (int i = 0; i < 7; i++) begin
         req0 = v[i].r0; req1 = v[i].r1;
         data0 = v[i].d0; data1 = v[i].d1; ss0 = v[i].s0; ss1 = v[i].s1;
         launch(v[i].g, v[i].g ? v[i].d1 : v[i].d0, v[i].g ? v[i].s1 : v[i].s0, 2);
         finish(v[i].g, v[i].eep, v[i].dly);
      end
      req0 = 1'b0; req1 = 1'b0;
      // stray SPI_done while idle
      SPI_done = 1'b1; EEP_data = 8'hAA;
      @(negedge clk);
      SPI_done = 1'b0;
      chk("idle_spurious_done", 32'({done1, done0}), 0);
      chk("idle_spurious_rdata", 32'(rdata), 32'(v[6].eep));
      chk("idle_busy", 32'(busy), 0);
      // stray SPI_done during LAUNCH
      req0 = 1'b1; data0 = 16'h4321; ss0 = 3'b010;
      @(negedge clk);
      SPI_done = 1'b1; EEP_data = 8'hAA;
      @(negedge clk);
      SPI_done = 1'b0;
      chk("launch_spurious_done", 32'({done1, done0}), 0);
      chk("launch_spurious_rdata", 32'(rdata), 32'(v[6].eep));
      launch(1'b0, 16'h4321, 3'b010, 0);
      finish(1'b0, 8'h96, 3);
      req0 = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      begin
         int n = 0;
         exp_t e;
         req1 = 1'b1; data1 = 16'hC0DE; ss1 = 3'b100;
         launch(1'b1, 16'hC0DE, 3'b100, 2);
         e = '{1'b1, 8'hFF, 1'b1};
         q.push_back(e);
         while (!(done0 || done1) && n < 40) begin
            @(negedge clk);
            n++;
         end
         chk("timeout_latency", 32'(n), 7);
         req1 = 1'b0;
         @(negedge clk);
         chk("timeout_busy_after", 32'(busy), 0);
         req0 = 1'b1; data0 = 16'h0F0F; ss0 = 3'b011;
         launch(1'b0, 16'h0F0F, 3'b011, 2);
         repeat (2) @(negedge clk);
      end
`else
      begin
         int bad = 0;
         req1 = 1'b1; data1 = 16'hC0DE; ss1 = 3'b100;
         launch(1'b1, 16'hC0DE, 3'b100, 2);
         repeat (1000) begin
            @(negedge clk);
            if (!busy || done0 || done1) bad++;
         end
         chk("wait_forever", 32'(bad), 0);
      end
`endif
      // reset while waiting: no completion, later SPI_done ignored
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk_reset();
      SPI_done = 1'b1; EEP_data = 8'h77;
      @(negedge clk);
      SPI_done = 1'b0;
      chk("late_done_ignored", 32'({done1, done0}), 0);
      chk("late_done_rdata", 32'(rdata), 0);
      chk("late_done_busy", 32'(busy), 0);
      // both held: grants alternate starting with requester 0
      req0 = 1'b1; req1 = 1'b1;
      data0 = 16'hA0A0; ss0 = 3'b001; data1 = 16'h5B5B; ss1 = 3'b010;
      for (int i = 0; i < 4; i++) begin
         logic g;
         g = i[0];
         launch(g, g ? 16'h5B5B : 16'hA0A0, g ? 3'b010 : 3'b001, 2);
         finish(g, 8'h10 + 8'(i), 1);
      end
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      chk("queue_drained", 32'(q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
